uart_cmd_parser: RTL and testbench

Downstream consumer of the UART receiver's byte stream (rx data byte plus one-cycle valid strobe). Parses ASCII decimal commands terminated by CR/LF and latches the value onto the board LED bus. Echoes every received byte back through a one-entry buffer to the UART transmitter using a start/busy handshake. Reports completion, rejected commands and echo overflow.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_cmd_parser_echo_buf.sv | 57 +++++
 rtl/uart_cmd_parser.sv | 136 +++++++++++++
 tb/tb_uart_cmd_parser.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART command parser: ASCII codes, parser states
// and the byte classifier used by the FSM.
package uart_pkg;

  localparam int LED_W_DEF = 6;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DIGITS = 2'd1;
  localparam logic [1:0] ST_ERROR  = 2'd2;

  typedef enum logic [1:0] {
    BC_DIGIT,
    BC_TERM,
    BC_ILLEGAL
  } byte_class_e;

  function automatic byte_class_e classify(input logic [7:0] b);
    if (b >= ASCII_ZERO && b <= ASCII_NINE) return BC_DIGIT;
    if (b == ASCII_CR || b == ASCII_LF)     return BC_TERM;
    return BC_ILLEGAL;
  endfunction

endpackage

// File: rtl/uart_cmd_parser_echo_buf.sv
// One-entry echo buffer feeding the UART transmitter through a start/busy
// handshake; flags (sticky) any byte that had to be dropped.
module uart_echo_buf (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       echo_ovf
);

  logic       full_q, full_d;
  logic [7:0] data_q, data_d;
  logic       sent_q, sent_d;
  logic       ovf_q, ovf_d;
  logic       drain;

  // sent_q blocks a second start in the cycle before tx_busy can rise
  assign drain = full_q && !tx_busy && !sent_q;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    ovf_d  = ovf_q;
    sent_d = drain;
    if (drain) full_d = 1'b0;
    if (in_valid) begin
      if (!full_q || drain) begin
        full_d = 1'b1;
        data_d = in_data;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= 8'h00;
      sent_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      sent_q <= sent_d;
      ovf_q  <= ovf_d;
    end
  end

  assign tx_start = drain;
  assign tx_data  = data_q;
  assign echo_ovf = ovf_q;

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses CR/LF-terminated ASCII decimal commands from the UART receiver and
// latches accepted values onto the LED bus; every byte is echoed back.
module uart_cmd_parser
  import uart_pkg::*;
#(
  parameter int LED_W      = LED_W_DEF,
  parameter int MAX_DIGITS = 3,
  parameter int ACC_W      = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_data_valid,
  input  logic             tx_busy,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  output logic [LED_W-1:0] led,
  output logic             cmd_valid,
  output logic             cmd_error,
  output logic             echo_ovf
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [ACC_W-1:0] LED_MAX = ACC_W'((2 ** LED_W) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LED_W-1:0] led_q, led_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             cmd_error_q, cmd_error_d;

  byte_class_e      bc;
  logic [ACC_W-1:0] digit_v;
  logic [ACC_W-1:0] acc_x10;

  assign bc      = classify(rx_data);
  assign digit_v = ACC_W'(rx_data[3:0]);
  assign acc_x10 = (acc_q << 3) + (acc_q << 1);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    led_d       = led_q;
    cmd_valid_d = 1'b0;
    cmd_error_d = 1'b0;
    if (rx_data_valid) begin
      case (state_q)
        ST_IDLE: begin
          case (bc)
            BC_DIGIT: begin
              acc_d   = digit_v;
              cnt_d   = CNT_W'(1);
              state_d = ST_DIGITS;
            end
            BC_ILLEGAL: state_d = ST_ERROR;
            default: ;  // bare terminators are empty lines
          endcase
        end
        ST_DIGITS: begin
          case (bc)
            BC_DIGIT: begin
              if (cnt_q == CNT_MAX) begin
                state_d = ST_ERROR;
                acc_d   = '0;
                cnt_d   = '0;
              end else begin
                acc_d = acc_x10 + digit_v;
                cnt_d = cnt_q + CNT_W'(1);
              end
            end
            BC_TERM: begin
              if (acc_q <= LED_MAX) begin
                led_d       = acc_q[LED_W-1:0];
                cmd_valid_d = 1'b1;
              end else begin
                cmd_error_d = 1'b1;
              end
              state_d = ST_IDLE;
              acc_d   = '0;
              cnt_d   = '0;
            end
            default: begin
              state_d = ST_ERROR;
              acc_d   = '0;
              cnt_d   = '0;
            end
          endcase
        end
        ST_ERROR: begin
          if (bc == BC_TERM) begin
            cmd_error_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      led_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      led_q       <= led_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_error_q <= cmd_error_d;
    end
  end

  assign led       = led_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_error = cmd_error_q;

  uart_echo_buf u_echo (
    .clk      (clk),
    .rst      (rst),
    .in_data  (rx_data),
    .in_valid (rx_data_valid),
    .tx_busy  (tx_busy),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .echo_ovf (echo_ovf)
  );

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: line-level reference model feeds
// expected command results and echo bytes; a monitor pops and compares.
module tb_uart_cmd_parser;

  localparam int LED_W = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       rx_data;
  logic             rx_data_valid;
  logic             tx_busy;
  logic [7:0]       tx_data;
  logic             tx_start;
  logic [LED_W-1:0] led;
  logic             cmd_valid;
  logic             cmd_error;
  logic             echo_ovf;

  uart_cmd_parser dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .tx_busy       (tx_busy),
    .tx_data       (tx_data),
    .tx_start      (tx_start),
    .led           (led),
    .cmd_valid     (cmd_valid),
    .cmd_error     (cmd_error),
    .echo_ovf      (echo_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit               is_err;
    logic [LED_W-1:0] led;
  } cmd_exp_t;

  cmd_exp_t   cmd_q[$];
  logic [7:0] echo_q[$];
  logic [7:0] line_q[$];
  logic [LED_W-1:0] m_led = '0;

  // Transmitter model: busy for a random 1..4 cycles following each start
  bit force_busy = 1'b0;
  int busy_cnt   = 0;
  bit start_seen = 1'b0;
  assign tx_busy = force_busy || (busy_cnt != 0);

  always @(negedge clk) start_seen = tx_start;
  always @(posedge clk) begin
    if (rst)             busy_cnt <= 0;
    else if (start_seen) busy_cnt <= int'($urandom_range(1, 4));
    else if (busy_cnt>0) busy_cnt <= busy_cnt - 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: judge a whole line once its terminator arrives
  task automatic model_byte(input logic [7:0] b);
    cmd_exp_t e;
    bit ok;
    int val;
    if (b == 8'h0D || b == 8'h0A) begin
      if (line_q.size() > 0) begin
        ok  = (line_q.size() <= 3);
        val = 0;
        foreach (line_q[i]) begin
          if (line_q[i] < 8'h30 || line_q[i] > 8'h39) ok = 0;
          else val = val * 10 + int'(line_q[i] - 8'h30);
        end
        if (ok && val <= 63) begin
          m_led    = LED_W'(val);
          e.is_err = 1'b0;
        end else begin
          e.is_err = 1'b1;
        end
        e.led = m_led;
        cmd_q.push_back(e);
      end
      line_q.delete();
    end else begin
      line_q.push_back(b);
    end
  endtask

  // Called just after a posedge; returns just after a posedge
  task automatic send_byte(input logic [7:0] b, input bit echo, input int gap);
    if (echo) echo_q.push_back(b);
    model_byte(b);
    rx_data       = b;
    rx_data_valid = 1'b1;
    @(posedge clk); #1;
    rx_data_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++)
      send_byte(s[i], 1'b1, int'($urandom_range(7, 10)));
  endtask

  task automatic drain();
    int n = 0;
    while ((cmd_q.size() != 0 || echo_q.size() != 0) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (cmd_q.size() != 0 || echo_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got cmd=%0d echo=%0d pending, expected 0", cmd_q.size(), echo_q.size());
      cmd_q.delete();
      echo_q.delete();
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  bit prev_start = 1'b0;
  always @(negedge clk) begin
    cmd_exp_t e;
    if (!rst) begin
      if (cmd_valid || cmd_error) begin
        if (cmd_valid && cmd_error) chk("both_pulses", 2'b11, 2'b01);
        else if (cmd_q.size() == 0) chk("unexpected_cmd_pulse", {cmd_valid, cmd_error}, 2'b00);
        else begin
          e = cmd_q.pop_front();
          chk("cmd_error_kind", cmd_error, e.is_err);
          chk("led_value", led, e.led);
        end
      end
      if (tx_start) begin
        if (prev_start) chk("tx_start_back_to_back", 1, 0);
        if (echo_q.size() == 0) chk("unexpected_tx_start", tx_data, 0);
        else chk("echo_byte", tx_data, echo_q.pop_front());
      end
    end
    prev_start = tx_start && !rst;
  end

  initial begin
    string s;
    int    n, w, pos;
    logic [7:0] bad;

    rst = 1'b1; rx_data = 8'h00; rx_data_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_led", led, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_error", cmd_error, 0);
    chk("rst_echo_ovf", echo_ovf, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    send_str("12\r");       drain(); chk("led_12", led, 12);
    send_str("5\r64\n");    drain(); chk("led_after_64", led, 5);
    send_str("1a3\r0007\r007\r"); drain(); chk("led_007", led, 7);
    send_str("9\r\n\r");    drain(); chk("led_9", led, 9);
    send_str("63\r");       drain(); chk("led_63", led, 63);
    chk("ovf_clear", echo_ovf, 0);

    for (int c = 0; c < 40; c++) begin
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(60, 67)) : int'($urandom_range(0, 999));
      s = $sformatf("%0d", n);
      w = int'($urandom_range(0, 2));
      for (int k = 0; k < w; k++) s = {"0", s};
      if ($urandom_range(0, 4) == 0) begin
        do bad = 8'($urandom_range(32, 126)); while (bad >= 8'h30 && bad <= 8'h39);
        pos = int'($urandom_range(0, s.len() - 1));
        s[pos] = bad;
      end
      s = {s, ($urandom_range(0, 1) != 0) ? "\r" : "\n"};
      if ($urandom_range(0, 3) == 0) s = {s, "\n"};
      send_str(s);
    end
    drain();
    chk("random_ovf_clear", echo_ovf, 0);

    // Overflow: echo blocked, second byte dropped but still parsed
    send_str("\r");
    drain();
    force_busy = 1'b1;
    send_byte(8'h31, 1'b1, 3);
    send_byte(8'h32, 1'b0, 1);
    chk("ovf_set", echo_ovf, 1);
    chk("ovf_no_start", tx_start, 0);
    force_busy = 1'b0;
    drain();
    send_str("\r");
    drain();
    chk("ovf_led_12", led, 12);
    chk("ovf_sticky", echo_ovf, 1);

    // Reset mid-command
    send_str("4");
    drain();
    rst = 1'b1;
    line_q.delete();
    m_led = '0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    chk("post_rst_led", led, 0);
    chk("post_rst_ovf", echo_ovf, 0);
    chk("post_rst_tx_start", tx_start, 0);
    @(posedge clk); #1;
    send_str("\r");
    drain();
    chk("rst_cmd_led", led, 0);
    chk("rst_cmd_ovf", echo_ovf, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
